video_rx_deframer: RTL and testbench
====================================

Name: video_rx_deframer

Overview:
Receive-side counterpart of the DVI output path. Takes a raw parallel video stream (24-bit pixel, DE, HSync, VSync, one pixel per clock, same clock domain) and recovers frame and line alignment. Checks the frame geometry and buffers pixels in a small FIFO. Re-emits pixels on the team's 24-bit Video/VideoReady/VideoValid interface, tagged with start-of-frame and end-of-line, for downstream SIFT processing stages.

Parameters:
Width, 800, active pixels per line
Height, 600, active lines per frame
FifoDepth, 16, FIFO entries; power of 2, minimum 4
HPol, 1, HSync active level
VPol, 1, VSync active level

Ports:
Clock  in  1  system clock; all logic on rising edge
Reset  in  1  asynchronous, active-low reset
PixelIn  in  24  incoming pixel {R,G,B}
DEIn  in  1  data enable; pixel valid when high
HSyncIn  in  1  horizontal sync, polarity HPol
VSyncIn  in  1  vertical sync, polarity VPol
Video  out  24  output pixel
VideoValid  out  1  Video holds a pixel
VideoReady  in  1  consumer accepts the pixel
StartOfFrame  out  1  Video is pixel (0,0) of a frame
EndOfLine  out  1  Video is the last pixel of a line (x = Width-1)
Locked  out  1  previous frame matched Width x Height with no errors
Overflow  out  1  sticky; FIFO overflowed; cleared only by Reset
FormatError  out  1  one-cycle pulse on a geometry mismatch

Behaviour:
- Single clock domain. Reset is asynchronous and active-low (Reset=0 resets).
- Reset values: all outputs 0, state HUNT, FIFO empty, x=0, y=0.
- Input stage: PixelIn, DEIn, HSyncIn and VSyncIn registered once. A second registered copy of DE and VSync is kept for edge detection.
- VSync leading edge (inactive to active level): frame boundary. DE falling edge: line end.
- State HUNT:
  - Discard all pixels.
  - On VSync leading edge: enter FRAME, x=0, y=0, clear the internal error flag.
- State FRAME:
  - Each registered cycle with DE=1:
    - If x < Width and y < Height: write {sof, eol, pixel} to the FIFO.
      - sof = (x==0 && y==0); eol = (x==Width-1).
    - Otherwise: drop the pixel and set the error flag.
    - Then increment x (saturates at Width).
  - On DE falling edge:
    - If x != Width, set the error flag.
    - Set x=0; increment y (saturates at Height).
  - On VSync leading edge:
    - If y != Height or the error flag is set: Locked=0 and FormatError pulses one cycle. Otherwise Locked=1.
    - Restart counting: x=0, y=0, clear the error flag, remain in FRAME.
  - A DE falling edge and a VSync leading edge in the same cycle: process line end first, then frame end.
- Overflow:
  - A write is attempted while the FIFO is full and no read occurs that cycle. The pixel is dropped.
  - Overflow is set (sticky) and Locked is cleared.
  - State returns to HUNT; the remainder of the frame is discarded.
  - Entries already in the FIFO still drain normally.
  - A write and a read in the same cycle when full both succeed.
- FIFO:
  - Circular buffer with log2(FifoDepth)+1-bit pointers; full and empty derived from the pointer MSBs.
  - Simultaneous read and write is allowed at any occupancy.
- Output handshake:
  - VideoValid = FIFO not empty. Video, StartOfFrame and EndOfLine show the FIFO head.
  - A transfer happens when VideoValid && VideoReady; the read pointer then advances.
  - While VideoValid=1 and VideoReady=0, Video, StartOfFrame and EndOfLine hold stable.
  - VideoValid never drops without a transfer, except on Reset.
- Latency: pixel at the input pins on cycle N is registered at N+1 and written at N+2. VideoValid rises at N+2 when the FIFO was empty.
- Reset mid-frame: the FIFO is flushed, the state returns to HUNT, and Locked and Overflow are cleared.

Test Plan:
(Bench parameters: Width=4, Height=3, FifoDepth=8, HPol=VPol=1; VideoReady=1 unless noted.)
1. Nominal:
   - Stimulus: VSync pulse, three lines of 4 DE cycles with pixels 0x000001..0x00000C, then VSync.
   - Response: 12 outputs in order. SOF only on 0x000001. EOL on 0x000004, 0x000008, 0x00000C. Locked=1 after the second VSync. FormatError never pulses.
2. Hunt:
   - Stimulus: pixels before the first VSync.
   - Response: no output at all; VideoValid stays 0.
3. Short line:
   - Stimulus: line 2 carries 3 pixels.
   - Response: 11 pixels output. FormatError pulses once at the next VSync; Locked=0.
4. Backpressure:
   - Stimulus: VideoReady=0 for the whole frame.
   - Response: 8 pixels buffered; the 9th sets Overflow=1. Releasing VideoReady drains exactly 0x000001..0x000008 with data stable while stalled. No further pixels until the next VSync.
5. Stall hold:
   - Stimulus: VideoReady toggles every cycle.
   - Response: each pixel is seen exactly once. Video is unchanged while VideoValid=1 and VideoReady=0.
6. Reset mid-frame:
   - Stimulus: assert Reset=0 after 5 pixels.
   - Response: VideoValid, Locked and Overflow go to 0 immediately. After release, no output until a new VSync leading edge.

Source files
------------

// File: rtl/video_rx_deframer.sv
// Receive-side deframer: recovers frame/line alignment from a raw DE/HSync/VSync
// pixel stream, checks geometry and re-emits pixels through a small FIFO.
module video_rx_deframer #(
  parameter int WIDTH      = 800,
  parameter int HEIGHT     = 600,
  parameter int FIFO_DEPTH = 16,
  parameter bit H_POL      = 1'b1,
  parameter bit V_POL      = 1'b1,
  parameter int DATA_W     = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] pixel_in,
  input  logic              de_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  output logic [DATA_W-1:0] video,
  output logic              video_valid,
  input  logic              video_ready,
  output logic              start_of_frame,
  output logic              end_of_line,
  output logic              locked,
  output logic              overflow,
  output logic              format_error
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int XW = $clog2(WIDTH + 1);
  localparam int YW = $clog2(HEIGHT + 1);
  localparam int EW = DATA_W + 2;
  localparam logic [XW-1:0] X_MAX  = XW'(WIDTH);
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_MAX  = YW'(HEIGHT);

  typedef enum logic {HUNT, FRAME} state_t;

  function automatic logic [XW-1:0] sat_inc_x(input logic [XW-1:0] v);
    return (v == X_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [YW-1:0] sat_inc_y(input logic [YW-1:0] v);
    return (v == Y_MAX) ? v : v + 1'b1;
  endfunction

  // Stage p0: registered inputs; p1 keeps DE/VSync history for edge detection
  logic [DATA_W-1:0] pixel_p0;
  logic              de_p0, de_p1, vs_p0, vs_p1, hs_p0;
  logic              hsync_unused;

  always_ff @(posedge clk) begin
    pixel_p0 <= pixel_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_p0 <= 1'b0;
      de_p1 <= 1'b0;
      vs_p0 <= ~V_POL;
      vs_p1 <= ~V_POL;
      hs_p0 <= ~H_POL;
    end else begin
      de_p0 <= de_in;
      de_p1 <= de_p0;
      vs_p0 <= vsync_in;
      vs_p1 <= vs_p0;
      hs_p0 <= hsync_in;
    end
  end

  // Line ends come from the DE falling edge, so HSync is registered but not consumed.
  assign hsync_unused = hs_p0;

  logic vs_lead, de_fall;
  assign vs_lead = (vs_p0 == V_POL) && (vs_p1 != V_POL);
  assign de_fall = de_p1 && !de_p0;

  // FIFO pointers and status
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          full, empty, rd_en, wr_req, wr_en;
  logic [EW-1:0] wr_entry, head;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = !empty && video_ready;
  assign wr_en = wr_req && (!full || rd_en);

  // Framing FSM and geometry counters
  state_t          state, state_n;
  logic [XW-1:0]   x, x_n;
  logic [YW-1:0]   y, y_n;
  logic            err, err_n, locked_n, ferr_n, ovf_n;

  assign wr_entry = {(x == '0) && (y == '0), x == X_LAST, pixel_p0};

  always_comb begin
    state_n  = state;
    x_n      = x;
    y_n      = y;
    err_n    = err;
    locked_n = locked;
    ferr_n   = 1'b0;
    ovf_n    = overflow;
    wr_req   = 1'b0;
    case (state)
      HUNT: begin
        if (vs_lead) begin
          state_n = FRAME;
          x_n     = '0;
          y_n     = '0;
          err_n   = 1'b0;
        end
      end
      FRAME: begin
        if (de_p0) begin
          if (x < X_MAX && y < Y_MAX) wr_req = 1'b1;
          else                        err_n  = 1'b1;
          x_n = sat_inc_x(x);
        end
        if (de_fall) begin
          if (x != X_MAX) err_n = 1'b1;
          x_n = '0;
          y_n = sat_inc_y(y);
        end
        // Frame verdict uses the line count after any coincident line end.
        if (vs_lead) begin
          if (y_n != Y_MAX || err_n) begin
            locked_n = 1'b0;
            ferr_n   = 1'b1;
          end else begin
            locked_n = 1'b1;
          end
          x_n   = '0;
          y_n   = '0;
          err_n = 1'b0;
        end
        if (wr_req && full && !rd_en) begin
          ovf_n    = 1'b1;
          locked_n = 1'b0;
          state_n  = HUNT;
        end
      end
      default: state_n = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= HUNT;
      x            <= '0;
      y            <= '0;
      err          <= 1'b0;
      locked       <= 1'b0;
      overflow     <= 1'b0;
      format_error <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
    end else begin
      state        <= state_n;
      x            <= x_n;
      y            <= y_n;
      err          <= err_n;
      locked       <= locked_n;
      overflow     <= ovf_n;
      format_error <= ferr_n;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Stage p1: FIFO storage; output is the head entry
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_entry;
  end

  assign head           = mem[rd_ptr[AW-1:0]];
  assign video_valid    = !empty;
  assign video          = empty ? '0 : head[DATA_W-1:0];
  assign end_of_line    = !empty && head[DATA_W];
  assign start_of_frame = !empty && head[DATA_W+1];

endmodule

// File: tb/tb_video_rx_deframer.sv
// Bench for video_rx_deframer: directed scenarios plus random frames, checked
// against a frame-level reference model and an output scoreboard.
module tb_video_rx_deframer;

  localparam int W = 4;
  localparam int H = 3;
  localparam int D = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] pixel_in = '0;
  logic        de_in = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0, video_ready = 1'b1;
  logic [23:0] video;
  logic        video_valid, start_of_frame, end_of_line, locked, overflow, format_error;

  video_rx_deframer #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(D), .H_POL(1'b1), .V_POL(1'b1),
                      .DATA_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .pixel_in(pixel_in), .de_in(de_in), .hsync_in(hsync_in),
    .vsync_in(vsync_in), .video(video), .video_valid(video_valid), .video_ready(video_ready),
    .start_of_frame(start_of_frame), .end_of_line(end_of_line), .locked(locked),
    .overflow(overflow), .format_error(format_error));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int fe_count = 0;
  int exp_fe = 0;
  bit exp_locked = 1'b0;
  bit exp_ovf = 1'b0;
  logic [25:0] exp_q[$];
  bit model_hunt = 1'b1;
  int model_y = 0;
  bit frame_err = 1'b0;
  int ready_mode = 0;
  logic [23:0] pix_ctr = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    case (ready_mode)
      0:       video_ready = 1'b1;
      1:       video_ready = 1'b0;
      2:       video_ready = ~video_ready;
      default: video_ready = ($urandom_range(3) != 0);
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    de_in = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_line(input int len, input bit rnd);
    for (int x = 0; x < len; x++) begin
      logic [23:0] p;
      p = rnd ? 24'($urandom) : pix_ctr;
      pix_ctr++;
      if (!model_hunt) begin
        if (x >= W || model_y >= H) frame_err = 1'b1;
        else if (ready_mode == 1 && exp_q.size() >= D) begin
          model_hunt = 1'b1;
          exp_ovf    = 1'b1;
          exp_locked = 1'b0;
        end else exp_q.push_back({x == 0 && model_y == 0, x == W - 1, p});
      end
      de_in = 1'b1;
      pixel_in = p;
      tick();
    end
    de_in = 1'b0;
    hsync_in = 1'b1;
    repeat (2) tick();
    hsync_in = 1'b0;
    repeat (6) tick();
    if (!model_hunt) begin
      if (len != W) frame_err = 1'b1;
      model_y++;
    end
  endtask

  task automatic vsync_pulse();
    bit ok;
    if (!model_hunt) begin
      ok = !frame_err && model_y == H;
      if (!ok) exp_fe++;
      exp_locked = ok;
    end
    model_hunt = 1'b0;
    model_y = 0;
    frame_err = 1'b0;
    de_in = 1'b0;
    vsync_in = 1'b1;
    repeat (2) tick();
    vsync_in = 1'b0;
    repeat (3) tick();
  endtask

  task automatic wait_drain(input string tag);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 300) begin
      tick();
      c++;
    end
    idle(4);
    check(tag, exp_q.size(), 0);
    check({tag, "_valid"}, video_valid, 1'b0);
  endtask

  // Output scoreboard and stall-stability monitor
  logic [25:0] prev_out;
  bit prev_stall = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        check("stall_valid", video_valid, 1'b1);
        check("stall_hold", {start_of_frame, end_of_line, video}, prev_out);
      end
      if (format_error) fe_count++;
      if (video_valid && video_ready) begin
        check("output_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check("output_data", {start_of_frame, end_of_line, video}, exp_q.pop_front());
      end
      prev_stall = video_valid && !video_ready;
      prev_out = {start_of_frame, end_of_line, video};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", video_valid, 1'b0);
    check("rst_video", video, 24'h0);
    check("rst_sof", start_of_frame, 1'b0);
    check("rst_eol", end_of_line, 1'b0);
    check("rst_locked", locked, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_format_error", format_error, 1'b0);
    rst_n = 1'b1;
    idle(2);

    // Hunt: pixels before any VSync are discarded
    pix_ctr = 24'h100;
    send_line(4, 1'b0);
    send_line(4, 1'b0);
    idle(4);
    check("hunt_valid", video_valid, 1'b0);
    check("hunt_fe", fe_count, 0);

    // Nominal frame 1..12
    vsync_pulse();
    pix_ctr = 24'h1;
    repeat (3) send_line(4, 1'b0);
    vsync_pulse();
    wait_drain("nominal_drain");
    check("nominal_locked", locked, exp_locked);
    check("nominal_fe", fe_count, exp_fe);

    // Ready toggling every cycle
    ready_mode = 2;
    repeat (3) send_line(4, 1'b1);
    vsync_pulse();
    wait_drain("toggle_drain");
    check("toggle_locked", locked, exp_locked);

    // Short second line
    ready_mode = 0;
    send_line(4, 1'b1);
    send_line(3, 1'b1);
    send_line(4, 1'b1);
    vsync_pulse();
    wait_drain("short_drain");
    check("short_fe", fe_count, exp_fe);
    check("short_locked", locked, exp_locked);

    // Random geometry and random ready
    for (int f = 0; f < 6; f++) begin
      int nl;
      ready_mode = 2 + (f % 2);
      nl = ($urandom_range(3) == 0) ? 2 + 2 * $urandom_range(1) : 3;
      for (int l = 0; l < nl; l++) begin
        int r;
        r = $urandom_range(5);
        send_line(r == 0 ? 3 : (r == 1 ? 5 : 4), 1'b1);
      end
      vsync_pulse();
      wait_drain("rand_drain");
      check("rand_locked", locked, exp_locked);
      check("rand_fe", fe_count, exp_fe);
    end

    // Backpressure: whole frame stalled, 9th pixel overflows
    ready_mode = 1;
    pix_ctr = 24'h1;
    repeat (3) send_line(4, 1'b0);
    check("bp_overflow", overflow, exp_ovf);
    check("bp_locked", locked, exp_locked);
    check("bp_buffered", exp_q.size(), D);
    ready_mode = 0;
    wait_drain("bp_drain");
    vsync_pulse();
    check("bp_hunt_fe", fe_count, exp_fe);
    repeat (3) send_line(4, 1'b1);
    vsync_pulse();
    wait_drain("bp_relock_drain");
    check("bp_relock", locked, exp_locked);
    check("bp_sticky", overflow, exp_ovf);

    // Reset mid-frame after 5 pixels
    ready_mode = 1;
    send_line(4, 1'b1);
    de_in = 1'b1;
    pixel_in = 24'hABCDEF;
    tick();
    check("pre_reset_valid", video_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", video_valid, 1'b0);
    check("mid_rst_locked", locked, 1'b0);
    check("mid_rst_overflow", overflow, 1'b0);
    exp_q.delete();
    model_hunt = 1'b1;
    model_y = 0;
    frame_err = 1'b0;
    exp_locked = 1'b0;
    exp_ovf = 1'b0;
    de_in = 1'b0;
    ready_mode = 0;
    idle(2);
    rst_n = 1'b1;
    send_line(4, 1'b1);
    send_line(4, 1'b1);
    idle(4);
    check("post_rst_valid", video_valid, 1'b0);
    vsync_pulse();
    check("post_rst_locked", locked, exp_locked);
    repeat (3) send_line(4, 1'b1);
    vsync_pulse();
    wait_drain("post_rst_drain");
    check("post_rst_relock", locked, exp_locked);
    check("post_rst_overflow", overflow, exp_ovf);
    check("final_fe", fe_count, exp_fe);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
